counter_seq_decoder: RTL
========================

# counter_seq_decoder

Receive-side decoder for the 2-bit T-flip-flop state counter driven by serial input `x`. It samples the counter's state bus and recovers, from each legal transition, the `x` bit that caused it. It flags illegal transitions and assembles the recovered bits into WIDTH-bit words. It sits downstream of the counter (or of a link carrying its state), so the serial stream can be checked and read back in the same lab design.

## Interface
- `WIDTH`, default 8: bits per assembled word (legal range ≥2).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `in_valid`  in  1  `state_in` holds a new counter state this cycle.
- `state_in`  in  2  counter state {q1,q0}.
- `locked`  out  1  reference state captured; decoding active.
- `bit_valid`  out  1  one-cycle pulse: `bit_out` is a newly decoded bit.
- `bit_out`  out  1  decoded `x`; holds last value between pulses.
- `word_valid`  out  1  one-cycle pulse: `word_out` is complete.
- `word_out`  out  WIDTH  last complete word, MSB = first bit received; holds between pulses.
- `err`  out  1  one-cycle pulse: illegal transition seen.
- `err_count`  out  8  illegal transitions since reset, saturating at 255.

## Operation
- Transition law (prev -> next):
  - For x=0, any state -> 01.
  - For x=1: 00->10, 01->10, 10->11, 11->00.
- FSM states:
  - UNLOCKED (reset state): the first `in_valid` stores `prev <= state_in` and moves to LOCKED. No bit is decoded on this sample.
  - LOCKED: each `in_valid` compares `state_in` against `prev`:
    - `state_in`==01: decoded bit 0.
    - `state_in`==next1(prev): decoded bit 1.
    - Otherwise illegal. Pulse `err`, increment `err_count` (saturating), discard the partial word (bit counter to 0, shift register cleared), emit no bit.
  - In every case `prev <= state_in`, so the decoder resynchronises on the illegal sample itself. The FSM stays LOCKED.
- Word assembly:
  - Each decoded bit is shifted into `shreg` ({shreg[WIDTH-2:0], bit}) and a bit counter (0..WIDTH-1) increments.
  - On the WIDTH-th bit: `word_out <= {shreg[WIDTH-2:0], bit}`, pulse `word_valid`, counter wraps to 0.
- Cycles with `in_valid`=0: no state change, all pulses low.
- Only reset returns the FSM to UNLOCKED.

## Timing
- All outputs are registered.
- `bit_valid`, `bit_out`, `err` and `locked` update on the edge that samples `in_valid`=1, i.e. they are visible the cycle after the input is presented.
- `word_valid` asserts in the same cycle as the WIDTH-th `bit_valid`.
- Throughput: one decoded bit per clock when `in_valid` is held high.
- Reset values:
  - `locked`, `bit_valid`, `bit_out`, `word_valid`, `err` = 0.
  - `word_out`, `err_count` = 0.
  - `prev`, `shreg`, bit counter = 0.
- Reset wins over a simultaneous `in_valid`: that sample is dropped.
- Reset mid-word discards the partial word and returns to UNLOCKED.
- `err` and `bit_valid` are never high in the same cycle.
- `err_count` at 255 stays at 255 on further errors; `err` still pulses.
- An illegal sample arriving when the bit counter is at WIDTH-1 produces no `word_valid`.

## Test plan
- **Basic decode:** reset, then `in_valid` states 00,01,10,11,00,01 -> 00 locks with no bit; then `bit_valid` pulses with `bit_out` = 0,1,1,1,0; `err`=0.
- **Word assembly (WIDTH=8):** ref 01, then 10,11,00,01,01,10,01,10 -> bits 1,1,1,0,0,1,0,1; `word_valid` pulses once with `word_out`=8'hE5 in the same cycle as the 8th `bit_valid`.
- **Illegal transition:** prev 00, `state_in` 11 -> `err` pulse, `err_count`=1, no `bit_valid`, partial word cleared; the next sample 01 decodes bit 0 relative to prev=11.
- **Gaps:** the same stream with `in_valid` low for 3 cycles between samples -> identical bits and word; no pulses in gap cycles.
- **Reset mid-word:** after 5 bits, `rst_n`=0 for 1 cycle -> all outputs 0 and `locked`=0; the next sample only re-locks, and the following 8 bits form a fresh word.
- **Saturation:** 300 illegal transitions (alternate 10,10,...) -> `err_count`=255 and `err` pulses on every sample.

Source files
------------

// File: rtl/counter_seq_decoder.sv
// Recovers the serial x bit from successive T-FF counter states, flags illegal steps and packs bits into words.
// All outputs registered (visible the cycle after in_valid); no backpressure, every in_valid sample is consumed.
module counter_seq_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       state_in,
    output logic             locked,
    output logic             bit_valid,
    output logic             bit_out,
    output logic             word_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_prev;
    logic [WIDTH-2:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_bit_valid;
    logic             r_bit_out;
    logic             r_word_valid;
    logic [WIDTH-1:0] r_word_out;
    logic             r_err;
    logic [7:0]       r_err_count;

    state_t           w_state_nxt;
    logic [1:0]       w_prev_nxt;
    logic [WIDTH-2:0] w_shreg_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_bit_valid_nxt;
    logic             w_bit_out_nxt;
    logic             w_word_valid_nxt;
    logic [WIDTH-1:0] w_word_out_nxt;
    logic             w_err_nxt;
    logic [7:0]       w_err_count_nxt;
    logic             w_legal;
    logic             w_bit;
    logic [WIDTH-1:0] w_sh_full;

    // Successor state when the counter is clocked with x=1.
    function automatic logic [1:0] next1(input logic [1:0] p);
        case (p)
            2'b00:   next1 = 2'b10;
            2'b01:   next1 = 2'b10;
            2'b10:   next1 = 2'b11;
            default: next1 = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= UNLOCKED;
            r_prev       <= '0;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_bit_valid  <= 1'b0;
            r_bit_out    <= 1'b0;
            r_word_valid <= 1'b0;
            r_word_out   <= '0;
            r_err        <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= w_prev_nxt;
            r_shreg      <= w_shreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_valid  <= w_bit_valid_nxt;
            r_bit_out    <= w_bit_out_nxt;
            r_word_valid <= w_word_valid_nxt;
            r_word_out   <= w_word_out_nxt;
            r_err        <= w_err_nxt;
            r_err_count  <= w_err_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_nxt       = r_prev;
        w_shreg_nxt      = r_shreg;
        w_cnt_nxt        = r_cnt;
        w_bit_valid_nxt  = 1'b0;
        w_bit_out_nxt    = r_bit_out;
        w_word_valid_nxt = 1'b0;
        w_word_out_nxt   = r_word_out;
        w_err_nxt        = 1'b0;
        w_err_count_nxt  = r_err_count;
        w_legal          = 1'b0;
        w_bit            = 1'b0;
        w_sh_full        = {r_shreg, 1'b0};

        if (in_valid) begin
            w_prev_nxt = state_in;
            case (r_state)
                UNLOCKED: w_state_nxt = LOCKED;
                default: begin
                    if (state_in == 2'b01) begin
                        w_legal = 1'b1;
                        w_bit   = 1'b0;
                    end else if (state_in == next1(r_prev)) begin
                        w_legal = 1'b1;
                        w_bit   = 1'b1;
                    end

                    w_sh_full = {r_shreg, w_bit};
                    if (w_legal) begin
                        w_bit_valid_nxt = 1'b1;
                        w_bit_out_nxt   = w_bit;
                        w_shreg_nxt     = w_sh_full[WIDTH-2:0];
                        if (r_cnt == CNT_LAST) begin
                            w_word_out_nxt   = w_sh_full;
                            w_word_valid_nxt = 1'b1;
                            w_cnt_nxt        = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end else begin
                        // Illegal step: drop the partial word, resync on this sample.
                        w_err_nxt   = 1'b1;
                        w_shreg_nxt = '0;
                        w_cnt_nxt   = '0;
                        if (r_err_count != 8'hFF) begin
                            w_err_count_nxt = r_err_count + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign locked     = (r_state == LOCKED);
    assign bit_valid  = r_bit_valid;
    assign bit_out    = r_bit_out;
    assign word_valid = r_word_valid;
    assign word_out   = r_word_out;
    assign err        = r_err;
    assign err_count  = r_err_count;

endmodule
